conv_div_32s_16ns_16_seq: RTL and testbench

Sequential divider for the Conv IP datapath, running in the opposite direction to the signed×unsigned product path. It takes a 32-bit signed accumulator and a 16-bit unsigned scale and returns a saturated 16-bit signed quotient plus the signed remainder. The core is a radix-2 restoring divider on magnitudes, with a valid/ready handshake on each side. It is used to requantize accumulated convolution sums back to 16-bit feature-map values.

---
 rtl/conv_div_32s_16ns_16_seq.sv | 135 +++++++++++++
 tb/tb_conv_div_32s_16ns_16_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_div_32s_16ns_16_seq.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor,
// saturated signed quotient and dividend-signed remainder, valid/ready on both sides.
module conv_div_32s_16ns_16_seq #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          DIVIDEND_W = 32,
  parameter int          DIVISOR_W  = 16,
  parameter int          QUOT_W     = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  ovf,
  output logic                  dz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] POS_LIM =
    {{(DIVIDEND_W-QUOT_W+1){1'b0}}, {(QUOT_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = POS_LIM + DIVIDEND_W'(1);
  localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [DIVIDEND_W-1:0]   quo_r;
  logic [DIVISOR_W:0]      rem_r;
  logic [DIVISOR_W-1:0]    div_r;
  logic                    neg_r;

  logic [DIVIDEND_W-1:0]   dividend_abs;
  logic [DIVISOR_W:0]      shifted;
  logic [DIVISOR_W+1:0]    trial;
  logic                    last_step;
  logic [QUOT_W-1:0]       q_fix;
  logic [DIVISOR_W:0]      r_fix;
  logic                    ovf_fix;
  logic                    dz_fix;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign last_step = (cnt == CNT_W'(DIVIDEND_W-1));

  // |-2^(W-1)| still fits because the working register is unsigned.
  assign dividend_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;

  // Partial remainder stays below the divisor, so its MSB is always zero here.
  assign shifted = {rem_r[DIVISOR_W-1:0], quo_r[DIVIDEND_W-1]};
  assign trial   = {1'b0, shifted} - {2'b00, div_r};

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_CALC;
      S_CALC:  if (last_step) state_nxt = S_FIX;
      S_FIX:                  state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    q_fix   = neg_r ? -quo_r[QUOT_W-1:0] : quo_r[QUOT_W-1:0];
    r_fix   = neg_r ? -rem_r : rem_r;
    ovf_fix = 1'b0;
    dz_fix  = (div_r == '0);
    if (dz_fix) begin
      q_fix = neg_r ? Q_MIN : Q_MAX;
      r_fix = '0;
    end else if (!neg_r && (quo_r > POS_LIM)) begin
      q_fix   = Q_MAX;
      ovf_fix = 1'b1;
    end else if (neg_r && (quo_r > NEG_LIM)) begin
      q_fix   = Q_MIN;
      ovf_fix = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      quo_r     <= '0;
      rem_r     <= '0;
      div_r     <= '0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            quo_r <= dividend_abs;
            rem_r <= '0;
            div_r <= divisor;
            neg_r <= dividend[DIVIDEND_W-1];
            cnt   <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (!trial[DIVISOR_W+1]) begin
            rem_r <= trial[DIVISOR_W:0];
            quo_r <= {quo_r[DIVIDEND_W-2:0], 1'b1};
          end else begin
            rem_r <= shifted;
            quo_r <= {quo_r[DIVIDEND_W-2:0], 1'b0};
          end
        end
        S_FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
          dz        <= dz_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_div_32s_16ns_16_seq.sv
// Scoreboard bench for the sequential divider: a C-semantics model pushes the
// expected result at each accept; results are popped and compared on out_valid.
module tb_conv_div_32s_16ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [16:0] remainder;
  logic        ovf;
  logic        dz;

  conv_div_32s_16ns_16_seq #(
    .ID(32'd1), .DIVIDEND_W(32), .DIVISOR_W(16), .QUOT_W(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [15:0] q;
    logic [16:0] r;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  longint accept_cyc = 0;
  longint prev_accept_cyc = 0;
  int     xfers = 0;

  always @(posedge ap_clk) begin
    cyc++;
    if (ap_rst_n && in_valid && in_ready) begin
      prev_accept_cyc = accept_cyc;
      accept_cyc = cyc;
    end
    if (ap_rst_n && out_valid && out_ready) xfers++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'(b);
    if (b == 16'd0) begin
      e.q = a[31] ? 16'h8000 : 16'h7fff;
      e.r = '0;
      e.ovf = 1'b0;
      e.dz = 1'b1;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.ovf = 1'b0;
      e.dz = 1'b0;
      if (q > 32767) begin
        q = 32767;
        e.ovf = 1'b1;
      end else if (q < -32768) begin
        q = -32768;
        e.ovf = 1'b1;
      end
      e.q = q[15:0];
      e.r = r[16:0];
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  task automatic recv(input int hold, input bit keep_ready, input bit check_lat);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL result_wait: out_valid=0 after %0d cycles", lat);
      return;
    end
    if (check_lat) begin
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL latency: got %0d cycles, required 33", lat);
      end
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_result: q=%h r=%h with empty scoreboard", quotient, remainder);
      return;
    end
    e = sb.pop_front();
    if ({quotient, remainder, ovf, dz} !== {e.q, e.r, e.ovf, e.dz}) begin
      miscompares++;
      $display("FAIL result: q=%h r=%h ovf=%b dz=%b, required q=%h r=%h ovf=%b dz=%b",
               quotient, remainder, ovf, dz, e.q, e.r, e.ovf, e.dz);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge ap_clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {quotient, remainder, ovf, dz} !== {e.q, e.r, e.ovf, e.dz}) begin
        miscompares++;
        $display("FAIL hold_%0d: vld=%b rdy=%b q=%h r=%h, required vld=1 rdy=0 q=%h r=%h",
                 i, out_valid, in_ready, quotient, remainder, e.q, e.r);
      end
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    if (!keep_ready) out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, ovf, dz} !== {1'b1, 1'b0, 16'h0, 17'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b vld=%b q=%h r=%h ovf=%b dz=%b, required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, ovf, dz);
    end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic test_basic();
    send(32'd1000, 16'd7);      recv(0, 0, 1);
    send(-32'sd1000, 16'd7);    recv(0, 0, 1);
    send(32'd999, 16'd1000);    recv(0, 0, 1);
    send(32'd0, 16'd13);        recv(0, 0, 1);
  endtask

  task automatic test_saturation();
    send(32'h7fffffff, 16'd1);  recv(0, 0, 1);
    send(32'h80000000, 16'hffff); recv(0, 0, 1);
    send(32'h80000000, 16'd1);  recv(0, 0, 1);
    send(32'd32767, 16'd1);     recv(0, 0, 1);
    send(32'd32768, 16'd1);     recv(0, 0, 1);
    send(-32'sd32768, 16'd1);   recv(0, 0, 1);
    send(-32'sd32769, 16'd1);   recv(0, 0, 1);
  endtask

  task automatic test_div_zero();
    send(32'd5, 16'd0);         recv(0, 0, 1);
    send(-32'sd5, 16'd0);       recv(0, 0, 1);
    send(32'd0, 16'd0);         recv(0, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [15:0] b;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(1, 300));
      send(a, b);
      recv(0, 0, 1);
    end
  endtask

  task automatic test_backpressure();
    int x0 = xfers;
    send(-32'sd123456, 16'd1000);
    recv(10, 0, 1);
    send(32'd77777, 16'd333);
    recv(0, 0, 1);
    vectors++;
    if (xfers - x0 !== 2) begin
      miscompares++;
      $display("FAIL bp_transfers: got %0d results, required 2", xfers - x0);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(32'd50000, 16'd9);
    recv(0, 1, 1);
    send(-32'sd40000, 16'd11);
    vectors++;
    if (accept_cyc - prev_accept_cyc !== 35) begin
      miscompares++;
      $display("FAIL initiation_interval: got %0d cycles, required 35", accept_cyc - prev_accept_cyc);
    end
    recv(0, 0, 1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    send(32'd1234567, 16'd5);
    repeat (15) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    void'(sb.pop_back());
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, ovf, dz} !== {1'b1, 1'b0, 16'h0, 17'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_values: rdy=%b vld=%b q=%h r=%h ovf=%b dz=%b, required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, ovf, dz);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_result: out_valid high %0d cycles, required 0", seen);
    end
    send(32'd100, 16'd3);
    recv(0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_div_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
